// File: rtl/time_set_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_set_controller_pkg
// Description : Shared definitions for the time-set controller: edit FSM
//               state encoding, field_sel codes, BCD field limits and the
//               BCD increment/decrement helper used by every edit field.
// Revision    : 1.0 - initial release
// ============================================================================
package time_set_controller_pkg;

    // Edit FSM states. IDLE and COMMIT are the only non-edit states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EDIT_HH = 3'd1,
        ST_EDIT_MM = 3'd2,
        ST_EDIT_SS = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    // field_sel codes (display blink select)
    localparam logic [1:0] FIELD_NONE    = 2'd0;
    localparam logic [1:0] FIELD_HOURS   = 2'd1;
    localparam logic [1:0] FIELD_MINUTES = 2'd2;
    localparam logic [1:0] FIELD_SECONDS = 2'd3;

    // Upper bound of each two-digit BCD field
    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // One BCD step over an 8-bit {tens,ones} field that wraps between 00 and
    // max_value. The input is always a legal in-range value because the field
    // registers are only ever written through this function or reset to zero,
    // so digit carries never produce non-BCD codes.
    function automatic logic [7:0] bcd_step(
        input logic [7:0] value,
        input logic [7:0] max_value,
        input logic       up
    );
        logic [3:0] tens;
        logic [3:0] ones;
        logic [7:0] result;
        tens = value[7:4];
        ones = value[3:0];
        if (up) begin
            if (value == max_value) begin
                result = 8'h00;
            end else if (ones == 4'd9) begin
                result = {tens + 4'd1, 4'd0};
            end else begin
                result = {tens, ones + 4'd1};
            end
        end else begin
            if (value == 8'h00) begin
                result = max_value;
            end else if (ones == 4'd0) begin
                result = {tens - 4'd1, 4'd9};
            end else begin
                result = {tens, ones - 4'd1};
            end
        end
        return result;
    endfunction

    // field_sel decode of a state
    function automatic logic [1:0] field_of(input state_t st);
        logic [1:0] code;
        case (st)
            ST_EDIT_HH: code = FIELD_HOURS;
            ST_EDIT_MM: code = FIELD_MINUTES;
            ST_EDIT_SS: code = FIELD_SECONDS;
            default:    code = FIELD_NONE;
        endcase
        return code;
    endfunction

    // True for the three edit states
    function automatic logic is_edit(input state_t st);
        return (st == ST_EDIT_HH) || (st == ST_EDIT_MM) || (st == ST_EDIT_SS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_controller_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : time_set_controller_button_conditioner
// Description : Conditions one raw push button: 2-flop synchronizer, counter
//               debounce, press-edge pulse and optional hold auto-repeat.
// Ports       : clock_1MHz  in  system clock
//               reset       in  synchronous active-high reset
//               btn_raw     in  raw asynchronous button, active-high
//               pulse       out one-cycle press / repeat event
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_controller_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clock_1MHz,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic            sync_meta;
    logic            sync_stable;
    logic            level;
    logic [DB_W-1:0] db_cnt;
    logic            press_q;
    logic            db_done;
    logic            rising_now;
    logic            falling_now;

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_armed;
    logic             rpt_q;
    logic             rpt_hit;

    // The debounced level flips on the cycle the run of "synced differs
    // from level" reaches DEBOUNCE_CYCLES.
    always_comb begin
        db_done     = (sync_stable != level) && (db_cnt == DB_LAST);
        rising_now  = db_done && !level;
        falling_now = db_done && level;
    end

    always_ff @(posedge clock_1MHz) begin
        if (reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            level       <= 1'b0;
            db_cnt      <= '0;
            press_q     <= 1'b0;
        end else begin
            sync_meta   <= btn_raw;
            sync_stable <= sync_meta;
            press_q     <= rising_now;
            if (sync_stable != level) begin
                if (db_done) begin
                    level  <= sync_stable;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                // Any bounce back to the current level restarts the count
                db_cnt <= '0;
            end
        end
    end

    // Before the first repeat the counter measures REPEAT_DELAY from the
    // press; afterwards (armed) it measures REPEAT_PERIOD between repeats.
    always_comb begin
        rpt_hit = rpt_armed ? (rpt_cnt == RPT_PERIOD_LAST) : (rpt_cnt == RPT_DELAY_LAST);
    end

    // Repeats only run while the level is high and is not being released on
    // this very cycle, so a release never produces a trailing step.
    always_ff @(posedge clock_1MHz) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            rpt_q     <= 1'b0;
        end else if (REPEAT_EN && level && !falling_now) begin
            if (rpt_hit) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b1;
                rpt_q     <= 1'b1;
            end else begin
                rpt_cnt   <= rpt_cnt + 1'b1;
                rpt_q     <= 1'b0;
            end
        end else begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            rpt_q     <= 1'b0;
        end
    end

    assign pulse = press_q | rpt_q;

endmodule
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : time_set_controller
// Description : Button-driven HH:MM:SS time entry. Conditions mode/up/down
//               buttons, steps the selected BCD field while editing and
//               issues a one-cycle load pulse when the edit is committed.
// Ports       : clock_1MHz  in   1  system clock, 1 MHz
//               reset       in   1  synchronous, active-high
//               btn_mode    in   1  raw mode button
//               btn_up      in   1  raw increment button
//               btn_down    in   1  raw decrement button
//               setTime     out 24  BCD {hT,hO,mT,mO,sT,sO}
//               load        out  1  one-cycle commit pulse
//               editing     out  1  high in any edit state
//               field_sel   out  2  0 none, 1 hours, 2 minutes, 3 seconds
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic        clock_1MHz,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [23:0] setTime,
    output logic        load,
    output logic        editing,
    output logic [1:0]  field_sel
);

    logic mode_ev;
    logic up_ev;
    logic down_ev;

    // Mode never auto-repeats: holding it must not skip through fields.
    time_set_controller_button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (1'b0)
    ) u_mode_cond (
        .clock_1MHz (clock_1MHz),
        .reset      (reset),
        .btn_raw    (btn_mode),
        .pulse      (mode_ev)
    );

    time_set_controller_button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (1'b1)
    ) u_up_cond (
        .clock_1MHz (clock_1MHz),
        .reset      (reset),
        .btn_raw    (btn_up),
        .pulse      (up_ev)
    );

    time_set_controller_button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (1'b1)
    ) u_down_cond (
        .clock_1MHz (clock_1MHz),
        .reset      (reset),
        .btn_raw    (btn_down),
        .pulse      (down_ev)
    );

    state_t      state_q;
    state_t      state_d;
    logic [23:0] time_q;
    logic [23:0] time_d;
    logic        step_up;
    logic        step_down;
    logic        step_any;

    // Up and down together cancel; mode wins over either of them.
    always_comb begin
        step_up   = up_ev && !down_ev && !mode_ev;
        step_down = down_ev && !up_ev && !mode_ev;
        step_any  = step_up || step_down;
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        case (state_q)
            ST_IDLE: begin
                if (mode_ev) begin
                    state_d = ST_EDIT_HH;
                end
            end
            ST_EDIT_HH: begin
                if (mode_ev) begin
                    state_d = ST_EDIT_MM;
                end else if (step_any) begin
                    time_d[23:16] = bcd_step(time_q[23:16], HOUR_MAX, step_up);
                end
            end
            ST_EDIT_MM: begin
                if (mode_ev) begin
                    state_d = ST_EDIT_SS;
                end else if (step_any) begin
                    time_d[15:8] = bcd_step(time_q[15:8], MINSEC_MAX, step_up);
                end
            end
            ST_EDIT_SS: begin
                if (mode_ev) begin
                    state_d = ST_COMMIT;
                end else if (step_any) begin
                    time_d[7:0] = bcd_step(time_q[7:0], MINSEC_MAX, step_up);
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they are registered
    // yet line up with the state register cycle for cycle.
    always_ff @(posedge clock_1MHz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            time_q    <= 24'h000000;
            load      <= 1'b0;
            editing   <= 1'b0;
            field_sel <= FIELD_NONE;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            load      <= (state_d == ST_COMMIT);
            editing   <= is_edit(state_d);
            field_sel <= field_of(state_d);
        end
    end

    assign setTime = time_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_controller
// Description : Self-checking bench for time_set_controller. A behavioural
//               model (sliding-window debounce, arithmetic repeat schedule,
//               integer time fields) is compared against the DUT every cycle,
//               alongside literal expectations for the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_controller;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic        clock_1MHz = 1'b0;
    logic        reset      = 1'b1;
    logic        btn_mode   = 1'b0;
    logic        btn_up     = 1'b0;
    logic        btn_down   = 1'b0;
    logic [23:0] setTime;
    logic        load;
    logic        editing;
    logic [1:0]  field_sel;

    always #5 clock_1MHz = ~clock_1MHz;

    time_set_controller #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clock_1MHz (clock_1MHz),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .setTime    (setTime),
        .load       (load),
        .editing    (editing),
        .field_sel  (field_sel)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Button index: 0 mode, 1 up, 2 down.
    // A debounced level flips once the last DB synchronized samples (raw
    // samples two cycles old) all disagree with it. Repeats fire at fixed
    // offsets RD, RD+RP, RD+2RP ... from the press while the level holds.
    // ------------------------------------------------------------------
    bit hist [3][DB+1];
    bit lvl  [3];
    bit ev   [3];
    int press_at [3];
    int m_state = 0;   // 0 idle, 1 hours, 2 minutes, 3 seconds, 4 commit
    int m_h = 0, m_m = 0, m_s = 0;
    int cyc = 0;

    function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    always @(posedge clock_1MHz) begin
        bit rawv [3];
        bit all_diff;
        int d;
        cyc++;
        rawv[0] = btn_mode;
        rawv[1] = btn_up;
        rawv[2] = btn_down;
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                for (int k = 0; k <= DB; k++) hist[b][k] = 1'b0;
                lvl[b] = 1'b0;
                ev[b]  = 1'b0;
                press_at[b] = 0;
            end
            m_state = 0;
            m_h = 0; m_m = 0; m_s = 0;
        end else begin
            // Edit FSM consumes the events produced on the previous cycle
            if (m_state == 4) begin
                m_state = 0;
            end else if (ev[0]) begin
                m_state = m_state + 1;
            end else if (m_state != 0 && ev[1] != ev[2]) begin
                d = ev[1] ? 1 : -1;
                case (m_state)
                    1: m_h = (m_h + d + 24) % 24;
                    2: m_m = (m_m + d + 60) % 60;
                    default: m_s = (m_s + d + 60) % 60;
                endcase
            end
            for (int b = 0; b < 3; b++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DB; k++) begin
                    if (hist[b][k] == lvl[b]) all_diff = 1'b0;
                end
                for (int k = DB; k >= 1; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = rawv[b];
                ev[b] = 1'b0;
                if (all_diff) begin
                    lvl[b] = !lvl[b];
                    if (lvl[b]) begin
                        ev[b] = 1'b1;
                        press_at[b] = cyc;
                    end
                end else if (b != 0 && lvl[b]) begin
                    d = cyc - press_at[b];
                    if (d == RD || (d > RD && (d - RD) % RP == 0)) ev[b] = 1'b1;
                end
            end
        end
    end

    bit load_seen = 1'b0;

    always @(negedge clock_1MHz) begin
        logic [3:0] exp_ctl;
        if (cyc > 0) begin
            exp_ctl = {(m_state == 4), (m_state >= 1 && m_state <= 3),
                       (m_state >= 1 && m_state <= 3) ? 2'(m_state) : 2'd0};
            check("model_setTime", {8'h0, setTime}, {8'h0, to_bcd(m_h, m_m, m_s)});
            check("model_ctl", {28'h0, load, editing, field_sel}, {28'h0, exp_ctl});
            if (load === 1'b1) load_seen = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clock_1MHz);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_mode = v;
            1:       btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    // Short clean press: one event, no repeat, fully released on return
    task automatic tap(input int b);
        @(negedge clock_1MHz);
        set_btn(b, 1'b1);
        cycles(8);
        set_btn(b, 1'b0);
        cycles(12);
    endtask

    task automatic tap_n(input int b, input int n);
        for (int i = 0; i < n; i++) tap(b);
    endtask

    // Press mode while in EDIT_SS and record the load pulse
    task automatic commit_watch(output int n_load, output logic [23:0] val);
        n_load = 0;
        val    = 24'h0;
        @(negedge clock_1MHz);
        btn_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock_1MHz);
            if (i == 8) btn_mode = 1'b0;
            if (load === 1'b1) begin
                n_load++;
                val = setTime;
            end
        end
    endtask

    initial begin
        int          n_load;
        logic [23:0] v;
        logic [2:0]  mask;
        int          hold;

        cycles(3);
        check("reset_setTime", {8'h0, setTime}, 32'h0);
        check("reset_ctl", {29'h0, load, editing, field_sel}, 32'h0);
        reset = 1'b0;
        cycles(2);

        // Bounced mode press: only the final stable hold counts
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_1MHz);
            btn_mode = (i % 2 == 0);
            @(negedge clock_1MHz);
        end
        @(negedge clock_1MHz);
        btn_mode = 1'b1;
        cycles(6);
        check("bounce_not_yet", {30'h0, field_sel}, 32'd0);
        cycles(1);
        check("bounce_field_hours", {30'h0, field_sel}, 32'd1);
        cycles(10);
        btn_mode = 1'b0;
        cycles(12);
        check("bounce_single_event", {30'h0, field_sel}, 32'd1);

        // Hours wrap in both directions
        tap(2);
        check("hh_down_wrap", {24'h0, setTime[23:16]}, 32'h23);
        tap(1);
        check("hh_up_wrap", {24'h0, setTime[23:16]}, 32'h00);
        tap(2);
        check("hh_down_again", {24'h0, setTime[23:16]}, 32'h23);
        check("hh_low_untouched", {16'h0, setTime[15:0]}, 32'h0000);

        // Minutes
        tap(0);
        tap(2);
        check("mm_down_wrap", {24'h0, setTime[15:8]}, 32'h59);
        tap(1);
        check("mm_up_wrap", {24'h0, setTime[15:8]}, 32'h00);
        check("mm_hours_kept", {24'h0, setTime[23:16]}, 32'h23);

        // Seconds, including auto-repeat
        tap(0);
        tap(2);
        check("ss_down_wrap", {24'h0, setTime[7:0]}, 32'h59);
        tap(1);
        check("ss_up_wrap", {24'h0, setTime[7:0]}, 32'h00);
        @(negedge clock_1MHz);
        btn_up = 1'b1;
        cycles(60);
        btn_up = 1'b0;
        cycles(15);
        check("ss_hold_repeat", {24'h0, setTime[7:0]}, 32'h09);
        tap(1);
        check("ss_carry_up", {24'h0, setTime[7:0]}, 32'h10);
        tap(2);
        check("ss_borrow_down", {24'h0, setTime[7:0]}, 32'h09);

        commit_watch(n_load, v);
        check("commit1_load_count", n_load, 32'd1);
        check("commit1_value", {8'h0, v}, 32'h230009);
        cycles(5);

        // Full pass to 12:34:56
        tap(0);
        tap_n(2, 11);
        tap(0);
        tap_n(2, 26);
        tap(0);
        tap_n(2, 13);
        commit_watch(n_load, v);
        check("commit2_load_count", n_load, 32'd1);
        check("commit2_value", {8'h0, v}, 32'h123456);
        check("commit2_idle", {30'h0, editing, field_sel != 2'd0}, 32'd0);
        cycles(5);

        // Reset in the middle of an auto-repeat hold in EDIT_MM
        tap(0);
        tap(0);
        load_seen = 1'b0;
        @(negedge clock_1MHz);
        btn_up = 1'b1;
        cycles(30);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("midreset_setTime", {8'h0, setTime}, 32'h0);
        check("midreset_ctl", {29'h0, load, editing, field_sel}, 32'h0);
        btn_up = 1'b0;
        cycles(15);
        check("midreset_no_load", {31'h0, load_seen}, 32'd0);

        // Simultaneous events
        tap(0);
        tap(1);
        @(negedge clock_1MHz);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        cycles(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cycles(12);
        check("updown_same_cycle", {8'h0, setTime}, 32'h010000);
        @(negedge clock_1MHz);
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        cycles(8);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        cycles(12);
        check("mode_up_field", {30'h0, field_sel}, 32'd2);
        check("mode_up_time", {8'h0, setTime}, 32'h010000);

        // Randomized phase, checked by the model every cycle
        for (int seg = 0; seg < 150; seg++) begin
            mask = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 2) != 0) mask[0] = 1'b0;
            if (mask == 3'b000) mask = 3'b010;
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                @(negedge clock_1MHz);
                for (int b = 0; b < 3; b++) begin
                    if (mask[b]) set_btn(b, ($urandom_range(0, 9) != 0));
                end
            end
            @(negedge clock_1MHz);
            btn_mode = 1'b0;
            btn_up   = 1'b0;
            btn_down = 1'b0;
            cycles($urandom_range(0, 15));
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                cycles($urandom_range(1, 2));
                reset = 1'b0;
            end
        end
        cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
